// File: rtl/rr_grant_dispatch_pkg.sv
// Shared definitions for the round-robin arbiter and its grant dispatcher:
// lane count, grant vector type, dispatcher state encoding and one-hot helpers.
package rr_pkg;

  localparam int RR_N   = 4;
  localparam int RR_IDW = $clog2(RR_N);

  typedef logic [RR_N-1:0]   rr_vec_t;
  typedef logic [RR_IDW-1:0] rr_idx_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } disp_state_e;

  // Two's-complement trick isolates the lowest set bit.
  function automatic rr_vec_t lowest_set(input rr_vec_t v);
    return v & (~v + rr_vec_t'(1));
  endfunction

  function automatic rr_idx_t onehot2idx(input rr_vec_t v);
    rr_idx_t idx;
    idx = '0;
    for (int k = 0; k < RR_N; k++) begin
      if (v[k]) idx = idx | rr_idx_t'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_grant_dispatch_if.sv
// Grant/payload/stream bundle between arbiter, dispatcher and downstream sink.
// stat_cnt_o exists only when DISPATCH_STATS_EN is defined.
interface rr_grant_dispatch_if #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int CW = 16
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]    gnt_i;
  logic [N*DW-1:0] req_data_i;
  logic [N-1:0]    ack_o;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [DW-1:0]   out_data_o;
  logic [IDW-1:0]  out_src_o;
  logic            err_o;
`ifdef DISPATCH_STATS_EN
  logic [N*CW-1:0] stat_cnt_o;

  modport slave (
    input  gnt_i, req_data_i, out_ready_i,
    output ack_o, out_valid_o, out_data_o, out_src_o, err_o, stat_cnt_o
  );
  modport master (
    output gnt_i, req_data_i, out_ready_i,
    input  ack_o, out_valid_o, out_data_o, out_src_o, err_o, stat_cnt_o
  );
`else
  modport slave (
    input  gnt_i, req_data_i, out_ready_i,
    output ack_o, out_valid_o, out_data_o, out_src_o, err_o
  );
  modport master (
    output gnt_i, req_data_i, out_ready_i,
    input  ack_o, out_valid_o, out_data_o, out_src_o, err_o
  );
`endif
endinterface

// File: rtl/rr_grant_dispatch_onehot_sel.sv
// Combinational grant decode: picks the lowest granted lane, its index and
// payload, and flags grant vectors with more than one bit set.
module rr_onehot_sel
  import rr_pkg::*;
#(
  parameter int DW = 8
) (
  input  rr_vec_t            gnt_i,
  input  logic [RR_N*DW-1:0] data_i,
  output rr_vec_t            sel_o,
  output rr_idx_t            idx_o,
  output logic               multi_o,
  output logic [DW-1:0]      data_o
);

  assign sel_o   = lowest_set(gnt_i);
  assign idx_o   = onehot2idx(sel_o);
  assign multi_o = (gnt_i & (gnt_i - rr_vec_t'(1))) != '0;

  always_comb begin
    data_o = '0;
    for (int k = 0; k < RR_N; k++) begin
      if (sel_o[k]) data_o = data_i[k*DW +: DW];
    end
  end

endmodule

// File: rtl/rr_grant_dispatch.sv
// Single-slot grant dispatcher: captures the granted lane's payload, acks the
// winner and streams it out. Optional per-lane counters: DISPATCH_STATS_EN.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_EMPTY | output register free, out_valid_o=0
// ST_FULL  | output register holds a payload, out_valid_o=1
module rr_grant_dispatch
  import rr_pkg::*;
#(
  parameter int N  = RR_N,
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic               clk,
  input  logic               reset,
  rr_grant_dispatch_if.slave bus
);

  localparam int IDW = $clog2(N);

  disp_state_e    state_q, state_d;
  logic [DW-1:0]  data_q, data_d;
  logic [IDW-1:0] src_q, src_d;
  logic           err_q;

  rr_vec_t        gnt_sel;
  rr_idx_t        gnt_idx;
  logic           multi_hot;
  logic [DW-1:0]  gnt_data;
  logic           can_load;
  logic           load;
  logic [N-1:0]   ack;

  rr_onehot_sel #(.DW(DW)) u_sel (
    .gnt_i   (bus.gnt_i),
    .data_i  (bus.req_data_i),
    .sel_o   (gnt_sel),
    .idx_o   (gnt_idx),
    .multi_o (multi_hot),
    .data_o  (gnt_data)
  );

  // A reset cycle never loads, so the winner is not acked and keeps requesting.
  assign can_load = ~reset & ((state_q == ST_EMPTY) | bus.out_ready_i);
  assign load     = can_load & (bus.gnt_i != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      err_q   <= multi_hot;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    if (load) begin
      state_d = ST_FULL;
      data_d  = gnt_data;
      src_d   = gnt_idx;
    end else if ((state_q == ST_FULL) && bus.out_ready_i) begin
      state_d = ST_EMPTY;
    end
  end

  always_comb begin
    ack             = gnt_sel & {N{can_load}};
    bus.ack_o       = ack;
    bus.out_valid_o = (state_q == ST_FULL);
    bus.out_data_o  = data_q;
    bus.out_src_o   = src_q;
    bus.err_o       = err_q;
  end

`ifdef DISPATCH_STATS_EN
  logic [N-1:0][CW-1:0] stat_q, stat_d;

  // Saturating per-lane accept counters.
  always_comb begin
    stat_d = stat_q;
    for (int k = 0; k < N; k++) begin
      if (ack[k] && (stat_q[k] != {CW{1'b1}})) stat_d[k] = stat_q[k] + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) stat_q <= '0;
    else       stat_q <= stat_d;
  end

  assign bus.stat_cnt_o = stat_q;
`endif

endmodule

// File: tb/tb_rr_grant_dispatch.sv
// Randomized and directed bench for rr_grant_dispatch against a behavioural
// single-slot model; stats checks are active when DISPATCH_STATS_EN is defined.
module tb_rr_grant_dispatch;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 3;

  logic clk;
  logic reset;

  int n_checks;
  int n_errors;

  // reference model state
  logic          m_full;
  logic [DW-1:0] m_data;
  int            m_src;
  logic          m_err;
  int            m_cnt[N];

  rr_grant_dispatch_if #(.N(N), .DW(DW), .CW(CW)) bus ();

  rr_grant_dispatch #(.N(N), .DW(DW), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_data = '0;
    m_src  = 0;
    m_err  = 1'b0;
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
  endtask

  // One clock: drive at negedge, check against the model, advance the model.
  task automatic cycle(input logic [N-1:0] g, input logic [N*DW-1:0] d,
                       input logic rdy, input logic rst);
    logic [N-1:0] e_ack;
    int lane;
    bus.gnt_i       = g;
    bus.req_data_i  = d;
    bus.out_ready_i = rdy;
    reset           = rst;
    #1;
    lane = -1;
    for (int k = N-1; k >= 0; k--) if (g[k]) lane = k;
    e_ack = '0;
    if (!rst && lane >= 0 && (!m_full || rdy)) e_ack[lane] = 1'b1;

    chk("ack", 32'(bus.ack_o), 32'(e_ack));
    chk("valid", 32'(bus.out_valid_o), 32'(m_full));
    chk("data", 32'(bus.out_data_o), 32'(m_data));
    chk("src", 32'(bus.out_src_o), 32'(m_src));
    chk("err", 32'(bus.err_o), 32'(m_err));
`ifdef DISPATCH_STATS_EN
    for (int k = 0; k < N; k++)
      chk("stat", 32'(bus.stat_cnt_o[k*CW +: CW]), 32'(m_cnt[k]));
`endif

    if (rst) begin
      model_reset();
    end else begin
      if (e_ack != '0) begin
        m_full = 1'b1;
        m_data = d[lane*DW +: DW];
        m_src  = lane;
        if (m_cnt[lane] < (1 << CW) - 1) m_cnt[lane]++;
      end else if (m_full && rdy) begin
        m_full = 1'b0;
      end
      m_err = ($countones(g) > 1);
    end
    @(negedge clk);
  endtask

  logic [N*DW-1:0] pay;
  logic [N*DW-1:0] pay2;
  logic [N-1:0]    g_r;

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.gnt_i = '0;
    bus.req_data_i = '0;
    bus.out_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    pay  = {8'h44, 8'hA5, 8'h22, 8'h11};
    pay2 = {8'h9C, 8'h77, 8'h66, 8'h55};

    // idle after reset
    for (int i = 0; i < 3; i++) cycle('0, pay, 1'b1, 1'b0);

    // single grant, lane 2
    cycle(4'b0100, pay, 1'b1, 1'b0);
    chk("t2_valid", 32'(bus.out_valid_o), 32'd1);
    chk("t2_data", 32'(bus.out_data_o), 32'hA5);
    chk("t2_src", 32'(bus.out_src_o), 32'd2);

    // streaming, no bubbles
    for (int k = 0; k < N; k++) begin
      g_r = '0;
      g_r[k] = 1'b1;
      cycle(g_r, pay, 1'b1, 1'b0);
      chk("t3_valid", 32'(bus.out_valid_o), 32'd1);
      chk("t3_src", 32'(bus.out_src_o), 32'(k));
    end

    // stall with a pending lane-3 grant
    for (int i = 0; i < 3; i++) cycle(4'b1000, pay2, 1'b0, 1'b0);
    chk("t4_hold", 32'(bus.out_data_o), 32'h44);
    cycle(4'b1000, pay2, 1'b1, 1'b0);
    chk("t4_data", 32'(bus.out_data_o), 32'h9C);
    chk("t4_src", 32'(bus.out_src_o), 32'd3);

    // multi-hot grant
    cycle(4'b0110, pay, 1'b1, 1'b0);
    chk("t5_src", 32'(bus.out_src_o), 32'd1);
    chk("t5_err", 32'(bus.err_o), 32'd1);
    cycle('0, pay, 1'b1, 1'b0);
    chk("t5_err_clr", 32'(bus.err_o), 32'd0);

    // reset while full and stalled
    cycle(4'b0001, pay, 1'b1, 1'b0);
    cycle(4'b0010, pay, 1'b0, 1'b1);
    chk("t6_valid", 32'(bus.out_valid_o), 32'd0);
`ifdef DISPATCH_STATS_EN
    chk("t6_stat_clr", 32'(bus.stat_cnt_o), 32'd0);
    for (int i = 0; i < 5; i++) cycle(4'b0001, pay, 1'b1, 1'b0);
    chk("t6_stat5", 32'(bus.stat_cnt_o[0 +: CW]), 32'd5);
    for (int i = 0; i < 5; i++) cycle(4'b0001, pay, 1'b1, 1'b0);
    chk("t6_stat_sat", 32'(bus.stat_cnt_o[0 +: CW]), 32'd7);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0, 1: g_r = '0;
        2: begin
          g_r = '0;
          g_r[$urandom_range(0, N-1)] = 1'b1;
        end
        default: g_r = N'($urandom_range(1, (1 << N) - 1));
      endcase
      cycle(g_r, (N*DW)'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 199) == 0));
    end
    cycle('0, pay, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
